// File: rtl/aes_pkg.sv
// Constants and GF(2^8) helpers shared by the AES encryption and decryption rounds.
// Holds the default state width, the inverse S-box table and xtime/multiply.
package aes_pkg;

  localparam int AES_DATA_LEN = 128;

  // Row-major 16x16 table: entry [b] is InvSubBytes(b).
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    logic [7:0] m;
    acc = 8'h00;
    p   = a;
    m   = b;
    for (int i = 0; i < 8; i++) begin
      if (m[0]) acc = acc ^ p;
      p = xtime(p);
      m = m >> 1;
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box for one byte.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] result
);

  assign result = INV_SBOX[value];

endmodule

// File: rtl/inv_round.sv
// One AES inverse cipher round as a 4-stage pipeline:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped on the last round).
module inv_round
  import aes_pkg::*;
#(
  parameter int DATA_LEN = AES_DATA_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic                last_in,
  input  logic                key_valid_in,
  input  logic [DATA_LEN-1:0] sub_key,
  output logic                valid_out,
  output logic [DATA_LEN-1:0] data_out,
  output logic                key_err
);

  // Flow control: valid_in qualifies data_in/last_in for exactly one cycle and
  // there is no ready; every valid state is accepted and appears on
  // valid_out/data_out four edges later, in order, one per cycle.

  logic                s1_valid, s2_valid, s3_valid;
  logic                s1_last,  s2_last,  s3_last;
  logic [DATA_LEN-1:0] s1_data,  s2_data,  s3_data;
  logic [DATA_LEN-1:0] key_q;
  logic                key_loaded;

  logic [DATA_LEN-1:0] shifted;
  logic [DATA_LEN-1:0] sub_bytes;
  logic [DATA_LEN-1:0] mixed;
  logic [DATA_LEN-1:0] round_key;

  // Byte k of the state sits at bits [DATA_LEN-1-8k -: 8]; k = 4*column + row.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = DATA_LEN - 1 - 8 * (4 * c + r);
      localparam int SRC = DATA_LEN - 1 - 8 * (4 * ((c - r + 4) % 4) + r);
      localparam int A0  = DATA_LEN - 1 - 8 * (4 * c + r);
      localparam int A1  = DATA_LEN - 1 - 8 * (4 * c + (r + 1) % 4);
      localparam int A2  = DATA_LEN - 1 - 8 * (4 * c + (r + 2) % 4);
      localparam int A3  = DATA_LEN - 1 - 8 * (4 * c + (r + 3) % 4);

      assign shifted[DST -: 8] = data_in[SRC -: 8];

      inv_sbox u_inv_sbox (
        .value  (s1_data[DST -: 8]),
        .result (sub_bytes[DST -: 8])
      );

      assign mixed[DST -: 8] = gf_mul(s3_data[A0 -: 8], 8'h0e)
                             ^ gf_mul(s3_data[A1 -: 8], 8'h0b)
                             ^ gf_mul(s3_data[A2 -: 8], 8'h0d)
                             ^ gf_mul(s3_data[A3 -: 8], 8'h09);
    end
  end

  // Until a key arrives the state is XORed with zero, but key_err records it.
  assign round_key = key_loaded ? key_q : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s3_valid   <= 1'b0;
      valid_out  <= 1'b0;
      s1_last    <= 1'b0;
      s2_last    <= 1'b0;
      s3_last    <= 1'b0;
      s1_data    <= '0;
      s2_data    <= '0;
      s3_data    <= '0;
      data_out   <= '0;
      key_q      <= '0;
      key_loaded <= 1'b0;
      key_err    <= 1'b0;
    end else begin
      s1_valid  <= valid_in;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      valid_out <= s3_valid;
      s1_last   <= valid_in & last_in;
      s2_last   <= s1_last;
      s3_last   <= s2_last;

      if (valid_in) s1_data <= shifted;
      if (s1_valid) s2_data <= sub_bytes;
      if (s2_valid) s3_data <= s2_data ^ round_key;
      if (s3_valid) data_out <= s3_last ? s3_data : mixed;

      // Key load is not forwarded: S3 above already used the old key_q.
      if (key_valid_in) begin
        key_q      <= sub_key;
        key_loaded <= 1'b1;
      end
      if (s2_valid && !key_loaded) key_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inv_round.sv
// Self-checking bench for inv_round using FIPS-197 inverse-cipher vectors.
module tb_inv_round;

  localparam int W = 128;

  localparam logic [W-1:0] KEY_A   = 128'h549932d1f08557681093ed9cbe2c974e;
  localparam logic [W-1:0] IN_A    = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [W-1:0] OUT_A   = 128'h54d990a16ba09ab596bbf40ea111702f;
  localparam logic [W-1:0] BOX_A   = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam logic [W-1:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [W-1:0] IN_B    = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [W-1:0] OUT_B   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [W-1:0] BOX_B   = 128'h00102030405060708090a0b0c0d0e0f0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_in = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         last_in = 1'b0;
  logic         key_valid_in = 1'b0;
  logic [W-1:0] sub_key = '0;
  logic         valid_out;
  logic [W-1:0] data_out;
  logic         key_err;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  inv_round #(.DATA_LEN(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .last_in      (last_in),
    .key_valid_in (key_valid_in),
    .sub_key      (sub_key),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .key_err      (key_err)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cyc=%0d, expected finish", cyc);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic last, input logic [W-1:0] exp);
    valid_in = 1'b1;
    data_in  = d;
    last_in  = last;
    tick();
    exp_q.push_back(exp);
    lat_q.push_back(cyc);
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic load_key(input logic [W-1:0] k);
    key_valid_in = 1'b1;
    sub_key      = k;
    tick();
    key_valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    tick();
    check_eq("drain", W'(exp_q.size()), '0);
  endtask

  // Scoreboard: every valid_out must match the oldest expected state, 3 edges after capture.
  always @(negedge clk) begin
    if (!reset && valid_out) begin
      if (exp_q.size() == 0) begin
        check_eq("stray_valid_out", W'(valid_out), '0);
      end else begin
        check_eq("data_out", data_out, exp_q.pop_front());
        check_eq("latency", W'(cyc), W'(lat_q.pop_front() + 3));
      end
    end
  end

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid_out", W'(valid_out), '0);
    check_eq("rst_data_out", data_out, '0);
    check_eq("rst_key_err", W'(key_err), '0);
    reset = 1'b0;
    tick();

    // No key ever loaded: outputs still flow, key_err sets at the S3 capture and sticks
    send(IN_A, 1'b1, BOX_A);
    check_eq("key_err_s1", W'(key_err), '0);
    send(IN_B, 1'b1, BOX_B);
    check_eq("key_err_s2", W'(key_err), '0);
    tick();
    check_eq("key_err_s3", W'(key_err), W'(1));
    repeat (4) tick();
    check_eq("key_err_sticky", W'(key_err), W'(1));
    wait_drain();

    // Reset with three states in flight
    send(IN_A, 1'b0, '0);
    send(IN_B, 1'b0, '0);
    send(IN_A, 1'b1, '0);
    reset = 1'b1;
    #1;
    check_eq("midrst_valid_out", W'(valid_out), '0);
    check_eq("midrst_key_err", W'(key_err), '0);
    check_eq("midrst_data_out", data_out, '0);
    exp_q.delete();
    lat_q.delete();
    tick();
    tick();
    reset = 1'b0;
    repeat (8) tick();
    check_eq("postrst_valid_out", W'(valid_out), '0);
    check_eq("postrst_key_err", W'(key_err), '0);

    // Single normal round
    load_key(KEY_A);
    send(IN_A, 1'b0, OUT_A);
    wait_drain();
    check_eq("hold_data_out", data_out, OUT_A);
    check_eq("hold_valid_out", W'(valid_out), '0);

    // Single final round
    load_key(KEY_B);
    send(IN_B, 1'b1, OUT_B);
    wait_drain();

    // Back-to-back, key switched while the first state is in S3 (no forwarding)
    key_valid_in = 1'b1;
    sub_key      = KEY_A;
    send(IN_A, 1'b0, OUT_A);
    key_valid_in = 1'b0;
    send(IN_B, 1'b1, OUT_B);
    key_valid_in = 1'b1;
    sub_key      = KEY_B;
    tick();
    key_valid_in = 1'b0;
    wait_drain();
    check_eq("final_key_err", W'(key_err), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_round.md
INV_ROUND -- requirements
Module: inv_round

Interface
REQ-001 SHALL have parameter DATA_LEN, default 128, meaning state/key width in bits (only 128 supported).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port valid_in  input  1  data_in/last_in carry a valid state this cycle.
REQ-005 SHALL have port data_in  input  DATA_LEN  cipher state; byte 0 = data_in[127:120], column-major (FIPS-197).
REQ-006 SHALL have port last_in  input  1  final inverse round; InvMixColumns bypassed.
REQ-007 SHALL have port key_valid_in  input  1  load sub_key into key register this cycle.
REQ-008 SHALL have port sub_key  input  DATA_LEN  decryption round key.
REQ-009 SHALL have port valid_out  output  1  data_out valid this cycle.
REQ-010 SHALL have port data_out  output  DATA_LEN  state after one inverse round.
REQ-011 SHALL have port key_err  output  1  sticky: a valid state reached AddRoundKey with no key loaded.

Function
REQ-012 SHALL implement a 4-stage registered pipeline: S1 InvShiftRows, S2 InvSubBytes, S3 AddRoundKey, S4 InvMixColumns (or pass-through when last flag set).
REQ-013 SHALL have fixed latency of 4 cycles: valid_in at edge N -> valid_out high in the cycle after edge N+3.
REQ-014 SHALL accept one state per cycle, no backpressure, no bubbles inserted; back-to-back inputs emerge back-to-back in order.
REQ-015 SHALL carry valid and last flags alongside data in every stage; stages with valid low hold their data registers unchanged.
REQ-016 InvShiftRows SHALL rotate row r right by r byte positions (row 0 unchanged).
REQ-017 InvSubBytes SHALL apply the FIPS-197 inverse S-box to each of the 16 bytes.
REQ-018 InvMixColumns SHALL multiply each column by {0e,0b,0d,09} circulant over GF(2^8), polynomial 0x11B.
REQ-019 Key register SHALL load sub_key on any edge where key_valid_in=1, independent of data flow, and set internal key_loaded.
REQ-020 S3 SHALL XOR with the key register value held before the edge; a key loaded at edge N applies to S3 captures at edge N+1 onward (no forwarding).
REQ-021 If S3 captures a valid state while key_loaded=0, key_err SHALL set and stay set until reset; the state SHALL still be XORed with zero key and propagate with valid.
REQ-022 valid_in while pipeline full SHALL simply shift; no overflow condition exists.
REQ-023 last flag SHALL affect only its own state; mixed last/non-last sequences SHALL be processed per state.

Reset
REQ-024 Reset SHALL asynchronously clear all stage valid bits, last flags, key_loaded and key_err; valid_out=0, key_err=0.
REQ-025 Reset SHALL clear data_out, all stage data registers and key register to 0.
REQ-026 Reset mid-operation SHALL discard all in-flight states; no valid_out until 4 cycles after first post-reset valid_in.

Structure
REQ-027 Shared package aes_pkg SHALL hold DATA_LEN default, inverse S-box table and GF(2^8) xtime/multiply functions, shared with the encryption round.
REQ-028 One sub-module inv_sbox (8-bit combinational inverse S-box) SHALL be instantiated 16 times in S2.

Verification
REQ-029 Load key 549932d1f08557681093ed9cbe2c974e, then valid_in with 7ad5fda789ef4e272bca100b3d9ff59f, last_in=0 -> 4 cycles later valid_out=1, data_out=54d990a16ba09ab596bbf40ea111702f.
REQ-030 Load key 000102030405060708090a0b0c0d0e0f, input 6353e08c0960e104cd70b751bacad0e7, last_in=1 -> data_out=00112233445566778899aabbccddeeff.
REQ-031 REQ-029 and REQ-030 inputs on consecutive cycles with key_valid_in timed per REQ-020 -> both outputs on consecutive cycles, correct order.
REQ-032 After reset, valid_in with no key ever loaded -> key_err=1 from S3 capture onward, valid_out still asserted; remains 1 until reset.
REQ-033 Assert reset with 3 states in flight -> valid_out=0, key_err=0 immediately; no stale output after reset release.
